// File: rtl/btn_op_decoder.sv
// btn_op_decoder
//   Synchronises and debounces NUM_BTN raw push-buttons, decodes the stable
//   button vector through OP_TABLE into an OP_W-bit ALU opcode and offers it
//   to the datapath over a valid/ready handshake. An opcode replaced before
//   it was accepted raises the sticky overrun flag.
//
// Ports
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   btn           : raw asynchronous buttons (default: [2]=btnl [1]=btnc [0]=btnr)
//   op_ready      : datapath accepts alu_op when high together with op_valid
//   clear_overrun : synchronous clear of overrun (a same-cycle set wins)
//   alu_op        : registered opcode
//   op_valid      : alu_op holds a new, unaccepted opcode
//   overrun       : sticky, an unaccepted opcode was overwritten
//   btn_db        : debounced button vector
module btn_op_decoder #(
  parameter int NUM_BTN   = 3,
  parameter int OP_W      = 4,
  parameter int DB_CYCLES = 4,
  parameter logic [(2**NUM_BTN)*OP_W-1:0] OP_TABLE = 32'hA97D_1062
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               op_ready,
  input  logic               clear_overrun,
  output logic [OP_W-1:0]    alu_op,
  output logic               op_valid,
  output logic               overrun,
  output logic [NUM_BTN-1:0] btn_db
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [OP_W-1:0]  OP_RST  = OP_TABLE[OP_W-1:0];

  typedef enum logic {IDLE, PEND} state_t;

  logic [NUM_BTN-1:0]            sync1_q, sync2_q;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_BTN-1:0]            db_q, db_d;
  logic                          chg_q, chg_d;
  state_t                        state_q, state_d;
  logic [OP_W-1:0]               op_q, op_d;
  logic                          ovr_q, ovr_d;
  logic [OP_W-1:0]               tbl_op;

  // Debounce: each bit counts consecutive mismatches between the
  // synchronised level and the accepted level; any agreement restarts it.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    chg_d = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = sync2_q[i];
          chg_d   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // chg_q marks the cycle after btn_db moved, so db_q already holds the new
  // vector when it is looked up here.
  assign tbl_op = OP_TABLE[int'(db_q)*OP_W +: OP_W];

  // Handshake: a change always loads; in PEND it overwrites the pending
  // opcode, which only counts as overrun when it was not accepted that cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ovr_d   = ovr_q & ~clear_overrun;
    unique case (state_q)
      IDLE: begin
        if (chg_q) begin
          op_d    = tbl_op;
          state_d = PEND;
        end
      end
      PEND: begin
        if (chg_q) begin
          op_d = tbl_op;
          if (!op_ready) ovr_d = 1'b1;
        end else if (op_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
      chg_q   <= 1'b0;
      state_q <= IDLE;
      op_q    <= OP_RST;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      chg_q   <= chg_d;
      state_q <= state_d;
      op_q    <= op_d;
      ovr_q   <= ovr_d;
    end
  end

  assign alu_op   = op_q;
  assign op_valid = (state_q == PEND);
  assign overrun  = ovr_q;
  assign btn_db   = db_q;

endmodule

// File: tb/tb_btn_op_decoder.sv
module tb_btn_op_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn;
  logic       op_ready, clear_overrun;
  logic [3:0] alu_op;
  logic       op_valid, overrun;
  logic [2:0] btn_db;

  logic [1:0] btn2;
  logic       op_ready2, clear2;
  logic [2:0] alu_op2;
  logic       op_valid2, overrun2;
  logic [1:0] btn_db2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  btn_op_decoder dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .op_ready(op_ready),
    .clear_overrun(clear_overrun), .alu_op(alu_op), .op_valid(op_valid),
    .overrun(overrun), .btn_db(btn_db)
  );

  btn_op_decoder #(.NUM_BTN(2), .OP_W(3), .DB_CYCLES(1), .OP_TABLE(12'o7531)) dut2 (
    .clk(clk), .rst_n(rst_n), .btn(btn2), .op_ready(op_ready2),
    .clear_overrun(clear2), .alu_op(alu_op2), .op_valid(op_valid2),
    .overrun(overrun2), .btn_db(btn_db2)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn = 3'b000; op_ready = 1'b0; clear_overrun = 1'b0;
    btn2 = 2'b00; op_ready2 = 1'b0; clear2 = 1'b0;
    tick(3);
    n_checks++;
    if ({alu_op, op_valid, overrun, btn_db} !== {4'b0010, 1'b0, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_values: got alu=%b v=%b ov=%b db=%b, want 0010 0 0 000",
               alu_op, op_valid, overrun, btn_db);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      n_checks++;
      if ({alu_op, op_valid, overrun} !== {4'b0010, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_after_reset cyc %0d: got alu=%b v=%b ov=%b, want 0010 0 0",
                 c, alu_op, op_valid, overrun);
      end
    end
  endtask

  task automatic test_reset_mid_debounce;
    btn = 3'b101;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_op, op_valid, btn_db} !== {4'b0010, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_debounce: got alu=%b v=%b db=%b, want 0010 0 000",
               alu_op, op_valid, btn_db);
    end
    btn = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      n_checks++;
      if ({alu_op, op_valid, overrun} !== {4'b0010, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_after_mid_reset cyc %0d: got alu=%b v=%b ov=%b, want 0010 0 0",
                 c, alu_op, op_valid, overrun);
      end
    end
  endtask

  task automatic test_single_press;
    op_ready = 1'b0;
    btn = 3'b100;
    tick(6);
    n_checks++;
    if (op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL press_early: op_valid=%b after 6 edges, want 0", op_valid);
    end
    tick(1);
    n_checks++;
    if ({op_valid, alu_op, btn_db} !== {1'b1, 4'b1101, 3'b100}) begin
      n_fail++;
      $display("FAIL press_latency: got v=%b alu=%b db=%b, want 1 1101 100",
               op_valid, alu_op, btn_db);
    end
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    n_checks++;
    if ({op_valid, alu_op} !== {1'b0, 4'b1101}) begin
      n_fail++;
      $display("FAIL press_accept: got v=%b alu=%b, want 0 1101", op_valid, alu_op);
    end
    // release and drain the 0010 opcode it produces
    op_ready = 1'b1;
    btn = 3'b000;
    tick(15);
    op_ready = 1'b0;
    n_checks++;
    if ({op_valid, alu_op, overrun} !== {1'b0, 4'b0010, 1'b0}) begin
      n_fail++;
      $display("FAIL press_release: got v=%b alu=%b ov=%b, want 0 0010 0",
               op_valid, alu_op, overrun);
    end
  endtask

  task automatic test_glitch;
    logic       seen_v, seen_db;
    logic [3:0] got[$];
    seen_v = 1'b0; seen_db = 1'b0;
    op_ready = 1'b0;
    btn = 3'b001;
    tick(3);
    btn = 3'b000;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (op_valid) seen_v = 1'b1;
      if (btn_db != 3'b000) seen_db = 1'b1;
    end
    n_checks++;
    if ({seen_v, seen_db} !== 2'b00) begin
      n_fail++;
      $display("FAIL glitch_3cyc: seen valid=%b db_change=%b, want 0 0", seen_v, seen_db);
    end
    op_ready = 1'b1;
    btn = 3'b001;
    tick(4);
    btn = 3'b000;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (op_valid) got.push_back(alu_op);
    end
    op_ready = 1'b0;
    n_checks++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL glitch_4cyc_count: got %0d opcodes, want 2", got.size());
    end else begin
      n_checks++;
      if ({got[0], got[1]} !== {4'b0110, 4'b0010}) begin
        n_fail++;
        $display("FAIL glitch_4cyc_ops: got %b,%b, want 0110,0010", got[0], got[1]);
      end
    end
  endtask

  task automatic test_overrun;
    op_ready = 1'b0;
    btn = 3'b011;
    tick(12);
    n_checks++;
    if ({alu_op, op_valid, overrun, btn_db} !== {4'b0001, 1'b1, 1'b0, 3'b011}) begin
      n_fail++;
      $display("FAIL ovr_first: got alu=%b v=%b ov=%b db=%b, want 0001 1 0 011",
               alu_op, op_valid, overrun, btn_db);
    end
    btn = 3'b111;
    tick(12);
    n_checks++;
    if ({alu_op, op_valid, overrun} !== {4'b1010, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovr_overwrite: got alu=%b v=%b ov=%b, want 1010 1 1",
               alu_op, op_valid, overrun);
    end
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    n_checks++;
    if ({overrun, op_valid, alu_op} !== {1'b0, 1'b1, 4'b1010}) begin
      n_fail++;
      $display("FAIL ovr_clear: got ov=%b v=%b alu=%b, want 0 1 1010",
               overrun, op_valid, alu_op);
    end
  endtask

  // Enters with 1010 pending from test_overrun.
  task automatic test_back_to_back;
    btn = 3'b110;
    tick(6);
    n_checks++;
    if ({op_valid, alu_op} !== {1'b1, 4'b1010}) begin
      n_fail++;
      $display("FAIL b2b_before: got v=%b alu=%b, want 1 1010", op_valid, alu_op);
    end
    op_ready = 1'b1;
    tick(1);
    n_checks++;
    if ({op_valid, alu_op, overrun} !== {1'b1, 4'b1001, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_load: got v=%b alu=%b ov=%b, want 1 1001 0",
               op_valid, alu_op, overrun);
    end
    tick(1);
    op_ready = 1'b0;
    n_checks++;
    if (op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: op_valid=%b, want 0", op_valid);
    end
  endtask

  task automatic test_set_wins;
    op_ready = 1'b0;
    btn = 3'b010;
    tick(12);
    n_checks++;
    if ({alu_op, op_valid, overrun} !== {4'b0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL setwins_pending: got alu=%b v=%b ov=%b, want 0000 1 0",
               alu_op, op_valid, overrun);
    end
    btn = 3'b011;
    tick(6);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    n_checks++;
    if ({alu_op, overrun} !== {4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL setwins: got alu=%b ov=%b, want 0001 1", alu_op, overrun);
    end
  endtask

  // Enters with 0001 pending and overrun set.
  task automatic test_reset_mid_handshake;
    btn = 3'b100;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_op, op_valid, overrun, btn_db} !== {4'b0010, 1'b0, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_hs: got alu=%b v=%b ov=%b db=%b, want 0010 0 0 000",
               alu_op, op_valid, overrun, btn_db);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(6);
    n_checks++;
    if (op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL held_release_early: op_valid=%b, want 0", op_valid);
    end
    tick(1);
    n_checks++;
    if ({op_valid, alu_op, overrun} !== {1'b1, 4'b1101, 1'b0}) begin
      n_fail++;
      $display("FAIL held_release: got v=%b alu=%b ov=%b, want 1 1101 0",
               op_valid, alu_op, overrun);
    end
  endtask

  task automatic test_param_sweep;
    btn2 = 2'b10;
    tick(3);
    n_checks++;
    if (op_valid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_early: op_valid=%b, want 0", op_valid2);
    end
    tick(1);
    n_checks++;
    if ({op_valid2, alu_op2, btn_db2} !== {1'b1, 3'd5, 2'b10}) begin
      n_fail++;
      $display("FAIL sweep: got v=%b alu=%0d db=%b, want 1 5 10",
               op_valid2, alu_op2, btn_db2);
    end
  endtask

  initial begin
    test_reset();
    test_param_sweep();
    test_reset_mid_debounce();
    test_single_press();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_set_wins();
    test_reset_mid_handshake();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
